// File: rtl/hazard_pkg.sv
// Shared types for the pipeline interlock: FSM states, forward selects, shadow bundles.
package hazard_pkg;

   localparam int SHADOW_AW = 5;

   typedef enum logic {RUN, STALL} state_e;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic [SHADOW_AW-1:0] rd;
      logic [SHADOW_AW-1:0] rs1;
      logic [SHADOW_AW-1:0] rs2;
      logic                 reg_write;
      logic                 mem_read;
   } ex_shadow_t;

   typedef struct packed {
      logic [SHADOW_AW-1:0] rd;
      logic                 reg_write;
   } wb_shadow_t;

   // x0 is hardwired zero, so it never produces a dependency
   function automatic logic reg_hit(
      input logic [SHADOW_AW-1:0] src,
      input logic [SHADOW_AW-1:0] rd,
      input logic                 we
   );
      return we && (src != '0) && (src == rd);
   endfunction

endpackage

// File: rtl/hazard_fwd_select.sv
// EX operand bypass select for one source operand.
module hazard_fwd_select
   import hazard_pkg::*;
(
   input  logic [SHADOW_AW-1:0] src_i,
   input  logic [SHADOW_AW-1:0] mem_rd_i,
   input  logic                 mem_we_i,
   input  logic [SHADOW_AW-1:0] wb_rd_i,
   input  logic                 wb_we_i,
   output logic [1:0]           sel_o
);

   // Younger producer in EX/MEM wins over MEM/WB
   always_comb begin
      sel_o = FWD_REG;
      if (reg_hit(src_i, mem_rd_i, mem_we_i)) begin
         sel_o = FWD_MEM;
      end else if (reg_hit(src_i, wb_rd_i, wb_we_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// 5-stage pipeline interlock: shadows, stall FSM, stall counter, forwarding.
// Define HAZARD_FWD_EN to build with EX forwarding (load-use stalls only).
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int STALL_CNT_W = 16,
   parameter int REG_AW      = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [REG_AW-1:0]      id_rs1,
   input  logic [REG_AW-1:0]      id_rs2,
   input  logic                   id_uses_rs2,
   input  logic [REG_AW-1:0]      id_rd,
   input  logic                   id_reg_write,
   input  logic                   id_mem_read,
   input  logic                   branch_taken,
   output logic                   pc_write,
   output logic                   if_id_write,
   output logic                   id_ex_bubble,
   output logic                   if_id_flush,
   output logic [1:0]             fwd_a,
   output logic [1:0]             fwd_b,
   output logic [STALL_CNT_W-1:0] stall_count
);

   ex_shadow_t             ex_q, ex_d;
   wb_shadow_t             mem_q, wb_q;
   state_e                 state_q;
   logic [STALL_CNT_W-1:0] cnt_q;
   logic                   hit_ex, stall;

   assign hit_ex = reg_hit(id_rs1, ex_q.rd, ex_q.reg_write)
                 | (id_uses_rs2 & reg_hit(id_rs2, ex_q.rd, ex_q.reg_write));

`ifdef HAZARD_FWD_EN
   assign stall = id_valid & ex_q.mem_read & hit_ex;

   hazard_fwd_select u_fwd_a (
      .src_i    (ex_q.rs1),
      .mem_rd_i (mem_q.rd),
      .mem_we_i (mem_q.reg_write),
      .wb_rd_i  (wb_q.rd),
      .wb_we_i  (wb_q.reg_write),
      .sel_o    (fwd_a)
   );

   hazard_fwd_select u_fwd_b (
      .src_i    (ex_q.rs2),
      .mem_rd_i (mem_q.rd),
      .mem_we_i (mem_q.reg_write),
      .wb_rd_i  (wb_q.rd),
      .wb_we_i  (wb_q.reg_write),
      .sel_o    (fwd_b)
   );
`else
   logic hit_mem;
   logic unused_shadow;

   assign hit_mem = reg_hit(id_rs1, mem_q.rd, mem_q.reg_write)
                  | (id_uses_rs2 & reg_hit(id_rs2, mem_q.rd, mem_q.reg_write));
   assign stall   = id_valid & (hit_ex | hit_mem);
   assign fwd_a   = FWD_REG;
   assign fwd_b   = FWD_REG;
   assign unused_shadow = ^{ex_q.rs1, ex_q.rs2, ex_q.mem_read, wb_q};
`endif

   assign pc_write     = ~stall;
   assign if_id_write  = ~stall;
   assign id_ex_bubble = stall;
   assign if_id_flush  = id_valid & branch_taken & ~stall;
   assign stall_count  = cnt_q;

   always_comb begin
      ex_d = '0;
      if (id_valid && !stall) begin
         ex_d.rd        = id_rd;
         ex_d.rs1       = id_rs1;
         ex_d.rs2       = id_rs2;
         ex_d.reg_write = id_reg_write;
         ex_d.mem_read  = id_mem_read;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= '{rd: ex_q.rd, reg_write: ex_q.reg_write};
         wb_q  <= mem_q;
         case (state_q)
            RUN:     if (stall)  state_q <= STALL;
            STALL:   if (!stall) state_q <= RUN;
            default: state_q <= RUN;
         endcase
         if (stall && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule
